commit_trace_buffer: RTL
========================

# commit_trace_buffer

Commit-trace tap and buffer sitting between the core's per-lane retire probes and the verification data interface that carries the commit stream into the bench. Each cycle it captures up to NRET retiring instructions, compacts them into program order in a multi-push FIFO, and presents them one record per cycle under valid/ready to the monitor side. It also checks commit-order continuity, flags overflow when the core outruns the consumer, and stops the stream after a halt record.

## Interface
- NRET, 2, number of retire lanes per cycle (1..4)
- XLEN, 64, PC width
- DEPTH, 16, FIFO entries; must be a power of two and at least 2*NRET
- ORDER_W, 10, commit order field width
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  NRET  per-lane retire valid
- in_pc  in  NRET*XLEN  per-lane retiring PC
- in_insn  in  NRET*32  per-lane instruction word
- in_order  in  NRET*ORDER_W  per-lane commit order
- in_dest_type  in  NRET*2  0 none, 1 gpr, 2 fpr, 3 vpr
- in_dest_idx  in  NRET*8  destination register index
- in_halt  in  NRET  per-lane sim-halt marker
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_pc / out_insn / out_order / out_dest_type / out_dest_idx / out_halt  out  XLEN/32/ORDER_W/2/8/1  head record fields
- occupancy  out  log2(DEPTH)+1  entries held
- overflow  out  1  sticky: a beat was dropped
- drop_cnt  out  16  dropped records, saturating
- order_err  out  1  sticky: order discontinuity seen
- err_expected / err_got  out  ORDER_W each  first mismatch capture
- done  out  1  halt record has been consumed

## Operation
- States: IDLE (no record popped yet), RUN, DONE. IDLE→RUN on first pop; IDLE/RUN→DONE on pop of a record with halt=1; DONE exits only on rst.
- Push: valid lanes are written in ascending lane index order into consecutive FIFO slots, skipping invalid lanes (lane 0 is older). k = popcount(in_valid).
- Push is all-or-nothing: if k > DEPTH − occupancy (occupancy as registered this cycle; a same-cycle pop does not free space for that push), the whole beat is dropped, overflow set, drop_cnt += k saturating at 0xFFFF.
- In DONE, inputs are ignored (not counted as drops), out_valid is 0, and no pops occur.
- Pop: when out_valid && out_ready, head advances by one.
- Order check on each pop: in IDLE, expected loads out_order+1. In RUN, if out_order ≠ expected, set order_err; on the first mismatch only, capture err_expected/err_got. Expected then resyncs to out_order+1. All order arithmetic is mod 2^ORDER_W, so wrap 1023→0 is legal.
- Simultaneous push and pop: occupancy_next = occupancy + k − 1.
- Pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- Reset values: out_valid 0, all out_* fields 0, occupancy 0, overflow 0, drop_cnt 0, order_err 0, err_* 0, done 0, state IDLE, pointers 0, expected 0.
- Latency: a record pushed in cycle N is visible on out_* in cycle N+1 when the FIFO was empty. Output fields are driven from registered storage.
- out_* is stable while out_valid && !out_ready.
- done rises the cycle after the halt pop. out_valid is 0 from that cycle onward.
- Throughput: 1 record per cycle out, up to NRET in.
- rst asserted mid-stream discards all contents. All outputs return to reset values the next cycle.

## Structure
- Package commit_trace_pkg: commit_rec_t struct (pc, insn, order, dest_type, dest_idx, halt), dest_type enum, state enum, default parameters.
- Sub-module commit_trace_fifo: multi-push (up to NRET), single-pop circular buffer of commit_rec_t with occupancy output. The top level holds the compaction, drop logic, order checker and FSM.

## Test plan
- Two lanes valid with orders 5 and 6, out_ready=1 → records popped order 5 then 6 on consecutive cycles; order_err stays 0; first out_valid appears 1 cycle after the push.
- Only lane 1 valid with pc 0x80000004 → single record with pc 0x80000004; occupancy goes 1 then 0.
- DEPTH=16, out_ready=0, 8 beats of 2 records, then one more beat → occupancy 16, overflow=1, drop_cnt=2; FIFO contents unchanged.
- Order sequence 1022, 1023, 0, 1 → no error. Sequence 3, 4, 7 → order_err=1, err_expected=5, err_got=7; a following 8 raises no new capture.
- Halt record at position 3 of 5 → exactly 3 pops, then done=1, out_valid=0; later input beats do not change drop_cnt.
- rst pulsed while occupancy=6 → next cycle occupancy=0, out_valid=0, all sticky flags cleared, state IDLE.

Source files
------------

// File: rtl/commit_trace_pkg.sv
// Shared types and default parameters for the commit trace buffer.
// Record layout, destination kinds and checker FSM states live here.
package commit_trace_pkg;

    localparam int CT_NRET    = 2;
    localparam int CT_XLEN    = 64;
    localparam int CT_DEPTH   = 16;
    localparam int CT_ORDER_W = 10;

    typedef enum logic [1:0] {
        DEST_NONE = 2'd0,
        DEST_GPR  = 2'd1,
        DEST_FPR  = 2'd2,
        DEST_VPR  = 2'd3
    } dest_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [CT_XLEN-1:0]    pc;
        logic [31:0]           insn;
        logic [CT_ORDER_W-1:0] order;
        dest_type_e            dest_type;
        logic [7:0]            dest_idx;
        logic                  halt;
    } commit_rec_t;

endpackage

// File: rtl/commit_trace_fifo.sv
// Multi-push (up to NRET per cycle), single-pop circular buffer of records.
// Ports: clk, rst, push_cnt_i/push_rec_i (compacted), pop_i, head_o, occupancy_o.
module commit_trace_fifo
    import commit_trace_pkg::*;
#(
    parameter int  NRET  = CT_NRET,
    parameter int  DEPTH = CT_DEPTH,
    localparam int CW    = $clog2(NRET + 1),
    localparam int PW    = $clog2(DEPTH),
    localparam int OW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] push_cnt_i,
    input  commit_rec_t   push_rec_i [NRET],
    input  logic          pop_i,
    output commit_rec_t   head_o,
    output logic [OW-1:0] occupancy_o
);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [OW-1:0] occ_q, occ_d;
    commit_rec_t   mem_q [DEPTH];

    always_comb begin
        wptr_d = wptr_q + PW'(push_cnt_i);
        rptr_d = rptr_q + PW'(pop_i);
        occ_d  = occ_q + OW'(push_cnt_i) - OW'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    // Storage needs no reset: pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NRET; i++) begin
            if (!rst && (i < int'(push_cnt_i))) begin
                mem_q[wptr_q + PW'(i)] <= push_rec_i[i];
            end
        end
    end

    assign head_o      = mem_q[rptr_q];
    assign occupancy_o = occ_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace tap: compacts retire lanes into a FIFO, streams one record
// per cycle, checks order continuity, counts drops, stops after halt.
module commit_trace_buffer
    import commit_trace_pkg::*;
#(
    parameter int  NRET    = CT_NRET,
    parameter int  XLEN    = CT_XLEN,
    parameter int  DEPTH   = CT_DEPTH,
    parameter int  ORDER_W = CT_ORDER_W,
    localparam int OW      = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRET-1:0]         in_valid,
    input  logic [NRET*XLEN-1:0]    in_pc,
    input  logic [NRET*32-1:0]      in_insn,
    input  logic [NRET*ORDER_W-1:0] in_order,
    input  logic [NRET*2-1:0]       in_dest_type,
    input  logic [NRET*8-1:0]       in_dest_idx,
    input  logic [NRET-1:0]         in_halt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [31:0]             out_insn,
    output logic [ORDER_W-1:0]      out_order,
    output logic [1:0]              out_dest_type,
    output logic [7:0]              out_dest_idx,
    output logic                    out_halt,
    output logic [OW-1:0]           occupancy,
    output logic                    overflow,
    output logic [15:0]             drop_cnt,
    output logic                    order_err,
    output logic [ORDER_W-1:0]      err_expected,
    output logic [ORDER_W-1:0]      err_got,
    output logic                    done
);

    localparam int CW = $clog2(NRET + 1);

    state_e             state_q;
    logic [ORDER_W-1:0] expected_q;
    logic               order_err_q;
    logic [ORDER_W-1:0] err_exp_q, err_got_q;
    logic               overflow_q;
    logic [15:0]        drop_cnt_q;
    logic               done_q;

    commit_rec_t   comp [NRET];
    commit_rec_t   head;
    logic [CW-1:0] k;
    logic [CW-1:0] push_cnt;
    logic [OW-1:0] occ;
    logic          live, fits, drop, pop;
    logic [16:0]   dsum;

    // Valid lanes packed to the front, lane 0 first (oldest).
    always_comb begin
        int n;
        n = 0;
        for (int l = 0; l < NRET; l++) comp[l] = '0;
        for (int l = 0; l < NRET; l++) begin
            if (in_valid[l]) begin
                comp[n].pc        = in_pc[l*XLEN +: XLEN];
                comp[n].insn      = in_insn[l*32 +: 32];
                comp[n].order     = in_order[l*ORDER_W +: ORDER_W];
                comp[n].dest_type = dest_type_e'(in_dest_type[l*2 +: 2]);
                comp[n].dest_idx  = in_dest_idx[l*8 +: 8];
                comp[n].halt      = in_halt[l];
                n++;
            end
        end
        k = CW'(n);
    end

    // Space check uses registered occupancy; a same-cycle pop frees nothing.
    assign live     = (state_q != ST_DONE);
    assign fits     = (OW'(k) <= (OW'(DEPTH) - occ));
    assign push_cnt = (live && fits) ? k : '0;
    assign drop     = live && (k != '0) && !fits;
    assign out_valid = live && (occ != '0);
    assign pop      = out_valid && out_ready;
    assign dsum     = {1'b0, drop_cnt_q} + 17'(k);

    commit_trace_fifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_cnt_i  (push_cnt),
        .push_rec_i  (comp),
        .pop_i       (pop),
        .head_o      (head),
        .occupancy_o (occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            expected_q  <= '0;
            order_err_q <= 1'b0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= dsum[16] ? 16'hFFFF : dsum[15:0];
            end
            if (pop) begin
                // Resync after every pop so one gap flags only once.
                expected_q <= head.order + 1'b1;
                if (state_q == ST_RUN && head.order != expected_q) begin
                    order_err_q <= 1'b1;
                    if (!order_err_q) begin
                        err_exp_q <= expected_q;
                        err_got_q <= head.order;
                    end
                end
                if (head.halt) begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= ST_RUN;
                end
            end
        end
    end

    assign out_pc        = out_valid ? head.pc : '0;
    assign out_insn      = out_valid ? head.insn : '0;
    assign out_order     = out_valid ? head.order : '0;
    assign out_dest_type = out_valid ? head.dest_type : DEST_NONE;
    assign out_dest_idx  = out_valid ? head.dest_idx : '0;
    assign out_halt      = out_valid && head.halt;
    assign occupancy     = occ;
    assign overflow      = overflow_q;
    assign drop_cnt      = drop_cnt_q;
    assign order_err     = order_err_q;
    assign err_expected  = err_exp_q;
    assign err_got       = err_got_q;
    assign done          = done_q;

endmodule
